// File: rtl/pipe_arbiter_pkg.sv
// Shared constants and types for the pipe arbiter: default sizes, pipe header
// field layout, and the candidate-set tag used by the grant logic.
package pipe_arbiter_pkg;

    localparam int DEF_WIDTH        = 128;
    localparam int DEF_STARVE_LIMIT = 16;
    localparam int IDX_W            = 3;

    localparam int HDR_LEN_LSB = 0;
    localparam int HDR_LEN_W   = 16;
    localparam int HDR_ID_LSB  = 16;
    localparam int HDR_ID_W    = 16;

    localparam logic [15:0] PRINTF_CHAN_ID = 16'd32767;

    typedef enum logic [1:0] {
        CAND_NONE,
        CAND_STARVED,
        CAND_PRIO,
        CAND_ALL
    } cand_src_e;

    function automatic logic [31:0] make_hdr(input logic [15:0] chan_id,
                                             input logic [15:0] len_words);
        logic [31:0] hdr;
        hdr = '0;
        hdr[HDR_ID_LSB  +: HDR_ID_W]  = chan_id;
        hdr[HDR_LEN_LSB +: HDR_LEN_W] = len_words;
        return hdr;
    endfunction

endpackage

// File: rtl/pipe_arbiter_if.sv
// Bundle of the arbiter's requester, merged-output and priority-load pipes.
// Enq handshake: a transfer happens at the clock edge where _ena is high; _ena may only be
// raised while the matching _rdy is high, and _rdy never depends on the same-cycle _ena.
interface pipe_arbiter_if #(
    parameter int NUM_IN = 4,
    parameter int WIDTH  = 128
);
    logic [NUM_IN-1:0]       in_enq_ena;
    logic [NUM_IN*WIDTH-1:0] in_enq_v;
    logic [NUM_IN-1:0]       in_enq_rdy;

    logic                    out_enq_ena;
    logic [WIDTH-1:0]        out_enq_v;
    logic                    out_enq_rdy;

    logic                    prio_set_ena;
    logic [NUM_IN-1:0]       prio_set_mask;
    logic                    prio_set_rdy;

    logic [2:0]              grant_last;
    logic [15:0]             forced_count;

    modport master (
        output in_enq_ena, in_enq_v, out_enq_rdy, prio_set_ena, prio_set_mask,
        input  in_enq_rdy, out_enq_ena, out_enq_v, prio_set_rdy, grant_last, forced_count
    );

    modport slave (
        input  in_enq_ena, in_enq_v, out_enq_rdy, prio_set_ena, prio_set_mask,
        output in_enq_rdy, out_enq_ena, out_enq_v, prio_set_rdy, grant_last, forced_count
    );
endinterface

// File: rtl/pipe_arbiter_rr_pick.sv
// Rotating first-one finder: returns the first set request scanning from i_start upward,
// wrapping modulo N. With no request, o_idx echoes i_start so the output mux stays deterministic.
module pipe_arbiter_rr_pick
    import pipe_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [N-1:0] w_rot;

    always_comb begin
        w_rot   = N'({i_req, i_req} >> i_start);
        o_idx   = i_start;
        o_valid = 1'b0;
        // Walk from the far end so the request nearest i_start is written last and wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'((int'(i_start) + k) % N);
            end
        end
    end

endmodule

// File: rtl/pipe_arbiter.sv
// Merges NUM_IN enq pipes into one through per-requester one-entry buffers, with round-robin
// grant, an optional high-priority mask, and wait counters that force starved traffic ahead.
module pipe_arbiter
    import pipe_arbiter_pkg::*;
#(
    parameter int NUM_IN       = 4,
    parameter int WIDTH        = DEF_WIDTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input logic           CLK,
    input logic           RST,
    pipe_arbiter_if.slave bus
);

    logic [NUM_IN-1:0] r_full;
    logic [WIDTH-1:0]  r_buf [NUM_IN];
    logic [7:0]        r_wait [NUM_IN];
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  r_grant_last;
    logic [NUM_IN-1:0] r_prio_mask;
    logic [15:0]       r_forced_count;

    logic [NUM_IN-1:0] w_starved;
    logic [NUM_IN-1:0] w_prio_full;
    logic [NUM_IN-1:0] w_cand;
    logic [NUM_IN-1:0] w_g_oh;
    cand_src_e         w_src;
    logic [IDX_W-1:0]  w_g;
    logic [IDX_W-1:0]  w_next_ptr;
    logic              w_g_valid;
    logic              w_out_ena;
    logic              w_forced;
    logic [WIDTH-1:0]  w_out_v;

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            w_starved[i] = r_full[i] && (r_wait[i] >= 8'(STARVE_LIMIT));
        end
    end

    assign w_prio_full = r_full & r_prio_mask;

    // Starved traffic outranks priority traffic, which outranks everything else.
    always_comb begin
        w_src  = CAND_NONE;
        w_cand = r_full;
        if (w_starved != '0) begin
            w_src  = CAND_STARVED;
            w_cand = w_starved;
        end else if (w_prio_full != '0) begin
            w_src  = CAND_PRIO;
            w_cand = w_prio_full;
        end else if (r_full != '0) begin
            w_src  = CAND_ALL;
        end
    end

    pipe_arbiter_rr_pick #(.N(NUM_IN)) u_rr_pick (
        .i_req   (w_cand),
        .i_start (r_rr_ptr),
        .o_idx   (w_g),
        .o_valid (w_g_valid)
    );

    always_comb begin
        w_out_v = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_g_oh[i] = (w_g == IDX_W'(i));
            if (w_g_oh[i]) begin
                w_out_v = r_buf[i];
            end
        end
    end

    assign w_out_ena  = w_g_valid && bus.out_enq_rdy;
    assign w_next_ptr = (w_g == IDX_W'(NUM_IN - 1)) ? '0 : w_g + IDX_W'(1);
    // Only counted when a non-priority grant actually displaced waiting priority traffic.
    assign w_forced   = w_out_ena && (w_src == CAND_STARVED) &&
                        ((w_g_oh & r_prio_mask) == '0) && (w_prio_full != '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_full         <= '0;
            r_rr_ptr       <= '0;
            r_grant_last   <= '0;
            r_prio_mask    <= '0;
            r_forced_count <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                r_buf[i]  <= '0;
                r_wait[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (w_out_ena && w_g_oh[i]) begin
                    r_full[i] <= 1'b0;
                    r_wait[i] <= '0;
                end else if (r_full[i]) begin
                    if (r_wait[i] != 8'hFF) begin
                        r_wait[i] <= r_wait[i] + 8'd1;
                    end
                end else if (bus.in_enq_ena[i]) begin
                    r_full[i] <= 1'b1;
                    r_buf[i]  <= bus.in_enq_v[i*WIDTH +: WIDTH];
                end
            end
            if (w_out_ena) begin
                r_rr_ptr     <= w_next_ptr;
                r_grant_last <= w_g;
            end
            if (w_forced && (r_forced_count != 16'hFFFF)) begin
                r_forced_count <= r_forced_count + 16'd1;
            end
            if (bus.prio_set_ena) begin
                r_prio_mask <= bus.prio_set_mask;
            end
        end
    end

    assign bus.in_enq_rdy   = ~r_full;
    assign bus.out_enq_ena  = w_out_ena;
    assign bus.out_enq_v    = w_out_v;
    assign bus.prio_set_rdy = 1'b1;
    assign bus.grant_last   = r_grant_last;
    assign bus.forced_count = r_forced_count;

endmodule

// File: tb/tb_pipe_arbiter.sv
// Self-checking bench for pipe_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic checked every cycle against a behavioural model of the grant rules.
module tb_pipe_arbiter;
  import pipe_arbiter_pkg::*;

  localparam int NI = 4;
  localparam int W  = 128;
  localparam int SL = 16;

  logic CLK;
  logic RST;

  pipe_arbiter_if #(.NUM_IN(NI), .WIDTH(W)) bus ();

  pipe_arbiter #(.NUM_IN(NI), .WIDTH(W), .STARVE_LIMIT(SL)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_vec = 0;
  int n_err = 0;

  // ---------------- scoreboard and reference model ----------------
  logic [W-1:0] exp_q[$];
  logic [NI-1:0] m_full;
  logic [W-1:0]  m_buf [NI];
  int            m_wait [NI];
  int            m_ptr;
  logic [NI-1:0] m_mask;
  int            m_last;
  int            m_forced;

  logic          obs_ena;
  logic [W-1:0]  obs_v;
  logic [NI-1:0] obs_rdy;
  logic [2:0]    obs_last;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] msg_of(input int src, input logic [7:0] tag);
    return {32'hC0DE_0000 | {24'h0, tag}, 32'(src), 24'h0, tag, make_hdr(16'(src), {8'h0, tag})};
  endfunction

  task automatic model_reset();
    m_full   = '0;
    m_ptr    = 0;
    m_mask   = '0;
    m_last   = 0;
    m_forced = 0;
    for (int i = 0; i < NI; i++) begin
      m_buf[i]  = '0;
      m_wait[i] = 0;
    end
    exp_q.delete();
  endtask

  // Winner: first requester at or after the pointer (wrapping) in the highest non-empty class.
  task automatic model_pick(output int g, output bit have, output bit from_starved);
    bit st [NI];
    bit any_st;
    bit any_pr;
    bit found;
    bit ok;
    int j;
    any_st = 0;
    any_pr = 0;
    have   = 0;
    for (int i = 0; i < NI; i++) begin
      st[i]  = m_full[i] && (m_wait[i] >= SL);
      any_st = any_st | st[i];
      any_pr = any_pr | (m_full[i] && m_mask[i]);
      have   = have | m_full[i];
    end
    from_starved = any_st;
    g     = m_ptr;
    found = 0;
    for (int k = 0; k < NI; k++) begin
      j = (m_ptr + k) % NI;
      if (any_st) ok = st[j];
      else if (any_pr) ok = m_full[j] && m_mask[j];
      else ok = m_full[j];
      if (ok && !found) begin
        g     = j;
        found = 1;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_cycle();
    int g;
    bit have;
    bit starv;
    logic exp_ena;
    logic [NI-1:0] exp_rdy;
    @(negedge CLK);
    model_pick(g, have, starv);
    exp_ena = have && bus.out_enq_rdy;
    exp_rdy = ~m_full;
    obs_ena  = bus.out_enq_ena;
    obs_v    = bus.out_enq_v;
    obs_rdy  = bus.in_enq_rdy;
    obs_last = bus.grant_last;
    chk("out_ena", W'(obs_ena), W'(exp_ena));
    chk("in_rdy", W'(obs_rdy), W'(exp_rdy));
    chk("grant_last", W'(obs_last), W'(m_last));
    chk("forced_count", W'(bus.forced_count), W'(m_forced));
    chk("prio_rdy", W'(bus.prio_set_rdy), W'(1));
    if (exp_ena) exp_q.push_back(m_buf[g]);
    if (obs_ena) begin
      if (exp_q.size() == 0) chk("out_data_unexpected", obs_v, ~obs_v);
      else chk("out_data", obs_v, exp_q.pop_front());
    end else begin
      chk("out_hold_data", obs_v, have ? m_buf[g] : m_buf[m_ptr]);
    end
    exp_q.delete();
    // advance the model to the state after the coming edge
    if (exp_ena) begin
      if (starv && !m_mask[g] && ((m_mask & m_full) != '0) && m_forced < 65535) m_forced++;
    end
    for (int i = 0; i < NI; i++) begin
      if (exp_ena && i == g) begin
        m_full[i] = 1'b0;
        m_wait[i] = 0;
      end else if (m_full[i]) begin
        if (m_wait[i] < 255) m_wait[i]++;
      end else if (bus.in_enq_ena[i]) begin
        m_full[i] = 1'b1;
        m_buf[i]  = bus.in_enq_v[i*W +: W];
      end
    end
    if (exp_ena) begin
      m_ptr  = (g + 1) % NI;
      m_last = g;
    end
    if (bus.prio_set_ena) m_mask = bus.prio_set_mask;
    @(posedge CLK);
    #1;
    bus.in_enq_ena   = '0;
    bus.prio_set_ena = 1'b0;
  endtask

  task automatic drive_tag(input logic [NI-1:0] ena, input logic [7:0] tag);
    bus.in_enq_ena = ena;
    for (int i = 0; i < NI; i++) bus.in_enq_v[i*W +: W] = msg_of(i, tag);
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    bus.in_enq_ena    = '0;
    bus.in_enq_v      = '0;
    bus.out_enq_rdy   = 1'b1;
    bus.prio_set_ena  = 1'b0;
    bus.prio_set_mask = '0;
    model_reset();
    @(negedge CLK);
    chk("rst_in_rdy", W'(bus.in_enq_rdy), W'(4'b1111));
    chk("rst_out_ena", W'(bus.out_enq_ena), W'(0));
    chk("rst_out_v", bus.out_enq_v, '0);
    chk("rst_grant_last", W'(bus.grant_last), W'(0));
    chk("rst_forced", W'(bus.forced_count), W'(0));
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  always @(posedge CLK) begin
    if (!RST) begin
      assert ((bus.in_enq_ena & ~bus.in_enq_rdy) == '0)
        else $error("bench drove enq strobe while not ready: %b", bus.in_enq_ena);
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic [NI-1:0] ena;
    logic [7:0]    tag;
    logic          out_rdy;
    logic          pset;
    logic [NI-1:0] pmask;
    logic          x_ena;
    int            x_src;
    logic [7:0]    x_tag;
    logic [NI-1:0] x_rdy;
    logic [2:0]    x_last;
  } vec_t;

  vec_t tbl [20];

  task automatic set_row(input int r, input logic [3:0] ena, input logic [7:0] tag,
                         input logic ordy, input logic pset, input logic [3:0] pmask,
                         input logic xena, input int xsrc, input logic [7:0] xtag,
                         input logic [3:0] xrdy, input logic [2:0] xlast);
    tbl[r] = '{ena, tag, ordy, pset, pmask, xena, xsrc, xtag, xrdy, xlast};
  endtask

  initial begin
    int lat;
    int cnt [NI];
    int prev;
    int breaks;
    int gaps;
    int id;
    logic [W-1:0] msg3;
    logic [NI-1:0] e;

    RST = 1'b1;
    apply_reset();

    set_row(0,  4'b0100, 1, 1, 0, 4'b0000, 0, 0, 0, 4'b1111, 0);
    set_row(1,  4'b0000, 0, 1, 0, 4'b0000, 1, 2, 1, 4'b1011, 0);
    set_row(2,  4'b0000, 0, 1, 0, 4'b0000, 0, 0, 0, 4'b1111, 2);
    set_row(3,  4'b0011, 2, 0, 0, 4'b0000, 0, 0, 0, 4'b1111, 2);
    for (int r = 4; r <= 8; r++) set_row(r, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0, 4'b1100, 2);
    set_row(9,  4'b0000, 0, 1, 0, 4'b0000, 1, 0, 2, 4'b1100, 2);
    set_row(10, 4'b0000, 0, 1, 0, 4'b0000, 1, 1, 2, 4'b1101, 0);
    set_row(11, 4'b1000, 3, 1, 0, 4'b0000, 0, 0, 0, 4'b1111, 1);
    set_row(12, 4'b0010, 4, 1, 0, 4'b0000, 1, 3, 3, 4'b0111, 1);
    set_row(13, 4'b1000, 4, 0, 0, 4'b0000, 0, 0, 0, 4'b1101, 3);
    set_row(14, 4'b0000, 0, 1, 1, 4'b1000, 1, 1, 4, 4'b0101, 3);
    set_row(15, 4'b0000, 0, 1, 0, 4'b0000, 1, 3, 4, 4'b0111, 1);
    set_row(16, 4'b1001, 5, 0, 0, 4'b0000, 0, 0, 0, 4'b1111, 3);
    set_row(17, 4'b0000, 0, 1, 0, 4'b0000, 1, 3, 5, 4'b0110, 3);
    set_row(18, 4'b0000, 0, 1, 0, 4'b0000, 1, 0, 5, 4'b1110, 3);
    set_row(19, 4'b0000, 0, 1, 1, 4'b0000, 0, 0, 0, 4'b1111, 0);

    for (int r = 0; r < 20; r++) begin
      drive_tag(tbl[r].ena, tbl[r].tag);
      bus.out_enq_rdy   = tbl[r].out_rdy;
      bus.prio_set_ena  = tbl[r].pset;
      bus.prio_set_mask = tbl[r].pmask;
      run_cycle();
      chk($sformatf("tbl%0d_ena", r), W'(obs_ena), W'(tbl[r].x_ena));
      chk($sformatf("tbl%0d_rdy", r), W'(obs_rdy), W'(tbl[r].x_rdy));
      chk($sformatf("tbl%0d_last", r), W'(obs_last), W'(tbl[r].x_last));
      if (tbl[r].x_ena) chk($sformatf("tbl%0d_data", r), obs_v, msg_of(tbl[r].x_src, tbl[r].x_tag));
    end

    // ---------------- starvation under priority traffic ----------------
    bus.prio_set_ena  = 1'b1;
    bus.prio_set_mask = 4'b0011;
    run_cycle();
    msg3 = msg_of(3, 8'hEE);
    lat  = -1;
    for (int c = 0; c < 40; c++) begin
      drive_tag('0, 8'(c));
      if (c == 0) begin
        bus.in_enq_ena = 4'b1011;
        bus.in_enq_v[3*W +: W] = msg3;
      end else if (lat < 0) begin
        bus.in_enq_ena = {2'b00, bus.in_enq_rdy[1:0]};
      end
      run_cycle();
      if (obs_ena && obs_v == msg3 && lat < 0) lat = c;
    end
    chk("starve_granted", W'(lat >= 0), W'(1));
    chk("starve_latency_le_17", W'(lat >= 0 && lat <= SL + 1), W'(1));
    chk("starve_forced_count", W'(bus.forced_count), W'(1));

    // ---------------- round-robin fairness ----------------
    apply_reset();
    for (int i = 0; i < NI; i++) cnt[i] = 0;
    prev = -1;
    breaks = 0;
    gaps = 0;
    for (int c = 0; c < 40; c++) begin
      drive_tag(bus.in_enq_rdy, 8'(c));
      run_cycle();
      if (obs_ena) begin
        id = int'(obs_v[HDR_ID_LSB +: HDR_ID_W]);
        if (id < NI) cnt[id]++;
        if (prev >= 0 && id != (prev + 1) % NI) breaks++;
        prev = id;
      end else if (prev >= 0) begin
        gaps++;
      end
    end
    for (int i = 0; i < NI; i++) chk($sformatf("rr_count_%0d", i), W'(cnt[i] >= 9 && cnt[i] <= 11), W'(1));
    chk("rr_rotation_breaks", W'(breaks), W'(0));
    chk("rr_gaps", W'(gaps), W'(0));

    // ---------------- asynchronous reset mid-operation ----------------
    for (int c = 0; c < 3; c++) run_cycle();
    bus.out_enq_rdy = 1'b0;
    drive_tag(4'b0111, 8'hD0);
    run_cycle();
    bus.out_enq_rdy = 1'b1;
    #2;
    RST = 1'b1;
    #1;
    chk("midrst_in_rdy", W'(bus.in_enq_rdy), W'(4'b1111));
    chk("midrst_out_ena", W'(bus.out_enq_ena), W'(0));
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int c = 0; c < 4; c++) begin
      run_cycle();
      chk("midrst_no_stale", W'(obs_ena), W'(0));
    end

    // ---------------- randomized traffic ----------------
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 49) == 0) begin
        bus.prio_set_ena  = 1'b1;
        bus.prio_set_mask = 4'($urandom_range(0, 15));
      end
      for (int i = 0; i < NI; i++) begin
        e[i] = bus.in_enq_rdy[i] && ($urandom_range(0, 99) < 55);
        bus.in_enq_v[i*W +: W] = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      bus.in_enq_ena  = e;
      bus.out_enq_rdy = ($urandom_range(0, 99) < 70);
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_arbiter.md
Name: pipe_arbiter

Overview:
- Merges NUM_IN independent 128-bit enq pipes (indication streams, printf streams, debug streams) into one 128-bit enq pipe toward the host transport.
- Generalises the fixed-priority two-way merge: each requester gets a one-entry holding buffer.
- Grant is round-robin, with an optional configurable high-priority mask.
- A per-requester wait counter bounds starvation when priority is in use.

Parameters:
- NUM_IN, 4, number of requester pipes (2..8).
- WIDTH, 128, message width in bits.
- STARVE_LIMIT, 16, cycles a non-priority buffered message may wait before it is forced ahead of priority traffic (1..255).

Ports:
- CLK  input  1  clock.
- RST  input  1  reset; asynchronous, active-high.
- in$enq__ENA  input  NUM_IN  per-requester enqueue strobe.
- in$enq$v  input  NUM_IN*WIDTH  requester i message in bits [i*WIDTH +: WIDTH].
- in$enq__RDY  output  NUM_IN  per-requester ready.
- out$enq__ENA  output  1  merged enqueue strobe.
- out$enq$v  output  WIDTH  merged message.
- out$enq__RDY  input  1  downstream ready.
- prio$set__ENA  input  1  load priority mask.
- prio$set$mask  input  NUM_IN  new priority mask; bit i=1 means requester i is high priority.
- prio$set__RDY  output  1  constant 1.
- grant$last  output  3  index of the most recent granted requester.
- forced$count  output  16  saturating count of starvation-forced grants.

Behaviour:
- State per requester i:
  - full[i], buf[i] (WIDTH bits), wait[i] (8-bit).
- Global state:
  - rr_ptr (3 bits), prio_mask (NUM_IN bits), grant$last, forced$count.
- Reset (async, RST=1):
  - full=0, wait=0, rr_ptr=0, prio_mask=0, grant$last=0, forced$count=0.
  - Outputs during and after reset: in$enq__RDY = all 1s, out$enq__ENA=0, out$enq$v = buf[0] contents (zero).
  - Reset asserted mid-operation discards all buffered messages; no partial output.
- Enqueue:
  - in$enq__RDY[i] = !full[i].
  - If in$enq__ENA[i] is asserted while full[i]=1, that is a protocol violation; the buffer is left unchanged (assertion in bench).
  - On ENA with RDY: buf[i] <= in$enq$v slice, full[i] <= 1. The message is available for grant the next cycle (1-cycle latency minimum).
- Candidate selection (combinational, same cycle):
  - starved = full & (wait >= STARVE_LIMIT).
  - If starved != 0, the candidate set is starved.
  - Else if (full & prio_mask) != 0, the candidate set is full & prio_mask.
  - Otherwise the candidate set is full.
  - Winner g = first set bit in the candidate set scanning rr_ptr, rr_ptr+1, ... modulo NUM_IN.
- Output:
  - out$enq__ENA = (full != 0) & out$enq__RDY.
  - out$enq$v = buf[g]. When nothing is full, out$enq$v = buf[rr_ptr] (don't-care, but deterministic).
- On out$enq__ENA:
  - full[g] <= 0, wait[g] <= 0, rr_ptr <= (g+1) mod NUM_IN, grant$last <= g.
  - If the grant came from the starved set and g is not in prio_mask, and prio_mask & full had another bit set, then forced$count <= forced$count+1, saturating at 16'hFFFF.
- Wait counters:
  - Each cycle, every full[i] that is not granted increments wait[i], saturating at 255.
  - wait increments while out$enq__RDY=0 as well.
- No same-cycle refill: a slot granted in cycle t accepts a new enqueue only in cycle t+1 (RDY derives from the registered full bit).
  - Per-requester throughput: 1 message per 2 cycles.
  - Aggregate throughput: 1 message per cycle with ≥2 requesters active.
- Priority update:
  - prio$set__ENA loads prio_mask at the clock edge and takes effect for the next cycle's selection.
  - It does not disturb buffers, counters or rr_ptr.
- Message contents pass through unmodified. No reordering within a requester; ordering across requesters is defined only by the grant rules above.

Decomposition:
- Shared package holds:
  - the WIDTH default (128);
  - the pipe header field positions (bits [15:0] = message length in words, bits [31:16] = method/channel id);
  - the printf channel id 16'd32767;
  - STARVE_LIMIT default.
- One natural sub-module: rr_pick, a combinational rotating first-one finder.
  - Inputs: request mask and start pointer.
  - Outputs: index and valid.
  - Instantiated once; the three-level candidate mux sits in front of it.

Test Plan:
- Reset then single input: enq in[2]=128'h...0002_0001 at cycle 0 with out$enq__RDY=1 -> out$enq__ENA=1 with that value at cycle 1, grant$last=2, in$enq__RDY[2]=1 at cycle 2.
- Round-robin fairness: NUM_IN=4, prio_mask=0, all four inputs enqueue every legal cycle for 40 cycles -> output grants rotate 0,1,2,3,0,...; each input gets 10 ±1 grants; no gaps after first message.
- Backpressure: fill inputs 0 and 1, hold out$enq__RDY=0 for 5 cycles -> out$enq__ENA=0, in$enq__RDY[1:0]=0, buffers unchanged, wait=5; release -> input 0 granted first, then input 1.
- Priority with starvation: prio_mask=4'b0001, input 0 refilled every legal cycle, input 3 holds one message -> input 3 is granted no later than STARVE_LIMIT+1=17 cycles after its enqueue, and forced$count increments by 1.
- Reset mid-operation: three buffers full, assert RST asynchronously between edges -> in$enq__RDY=4'b1111 and out$enq__ENA=0 immediately; after deassert no stale message appears.
- Priority update timing: prio$set__ENA with mask 4'b1000 in the same cycle inputs 1 and 3 are full, rr_ptr=0 -> that cycle grants 1, next cycle grants 3.
